// File: rtl/mul_add_structural_if.sv
// Handshake/operand bundle for the sequential multiply-add unit.
// The master launches operations and the slave (the multiply-add unit) returns results.
interface mul_add_structural_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] A;
    logic             ok;
    logic             err;
    logic             busy;

    modport master (
        output start, D, B, R,
        input  A, ok, err, busy
    );

    modport slave (
        input  start, D, B, R,
        output A, ok, err, busy
    );
endinterface

// File: rtl/mul_add_structural.sv
// Sequential multiply-add: A = D*B + R.
// This is a shift-and-add unit that handles one multiplier bit per clock.
// It rebuilds a dividend from the quotient (D), the divisor (B) and the remainder (R).
// Optional feature macro MULADD_REM_CHECK_EN adds one extra error source:
// err is also raised when the captured remainder is not smaller than the captured divisor.
module mul_add_structural #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mul_add_structural_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   res;
    logic               ok_flag;
    logic               err_flag;
    logic               busy_flag;
    logic [2*WIDTH-1:0] acc_next;
`ifdef MULADD_REM_CHECK_EN
    logic               rem_bad;
`endif

    // Accumulator value after the current RUN step (add multiplicand when multiplier LSB set)
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // Control FSM and datapath: launch capture, one shift-add step per clock, result hold
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            res       <= '0;
            ok_flag   <= 1'b0;
            err_flag  <= 1'b0;
            busy_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc       <= {{WIDTH{1'b0}}, bus.R};
                        mcand     <= {{WIDTH{1'b0}}, bus.B};
                        mplier    <= bus.D;
                        cnt       <= '0;
                        ok_flag   <= 1'b0;
                        err_flag  <= 1'b0;
                        busy_flag <= 1'b1;
`ifdef MULADD_REM_CHECK_EN
                        rem_bad   <= (bus.R >= bus.B);
`endif
                        state     <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        res       <= acc_next[WIDTH-1:0];
`ifdef MULADD_REM_CHECK_EN
                        err_flag  <= (|acc_next[2*WIDTH-1:WIDTH]) | rem_bad;
`else
                        err_flag  <= |acc_next[2*WIDTH-1:WIDTH];
`endif
                        ok_flag   <= 1'b1;
                        busy_flag <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // A held start keeps the result presented and never retriggers
                    if (!bus.start) begin
                        ok_flag <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.A    = res;
    assign bus.ok   = ok_flag;
    assign bus.err  = err_flag;
    assign bus.busy = busy_flag;
endmodule
